alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes a 32x32 unsigned multiply, keeping the low 32 bits of the product.
- Uses shift-and-add and drives the shared single-cycle ALU through its op/a/b/shamt ports, reading the ALU result y back each cycle.
- Sits beside the execute-stage ALU and owns the ALU inputs only while busy; an external mux selects between the pipeline and this block.
- Provides the MULT capability without a dedicated multiplier array.

Parameters:
- WIDTH, 32, operand/result width; must equal the ALU width.
- CNT_W, 5, iteration counter width; 2**CNT_W must equal WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  multiplicand, captured on an accepted start.
- b_in  input  WIDTH  multiplier, captured on an accepted start.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  WIDTH  low WIDTH bits of a_in*b_in; held until the next accepted start.
- alu_op  output  3  ALU opcode: ADD=010, SLL=100, SRL=101, AND=000.
- alu_a  output  WIDTH  ALU operand a.
- alu_b  output  WIDTH  ALU operand b.
- alu_shamt  output  5  ALU shift amount.
- alu_y  input  WIDTH  ALU result (combinational from the alu_* outputs).

Behaviour:
- Registers: mcand, mplier, prod (WIDTH each), cnt (CNT_W), state.
- Reset: state=IDLE, busy=0, done=0, result=0, prod=0, cnt=0; alu_op=AND, alu_a=0, alu_b=0, alu_shamt=0.
- alu_* outputs are combinational from state and registers.
- IDLE:
  - ALU driven with AND/0/0/0.
  - start=1: mcand<=a_in, mplier<=b_in, prod<=0, cnt<=0.
  - Next state is ADD if b_in[0]=1, otherwise SHL.
- ADD:
  - ALU driven with op=ADD, a=prod, b=mcand; prod<=alu_y.
  - Next state SHL.
- SHL:
  - ALU driven with op=SLL, a=mcand, shamt=1; mcand<=alu_y.
  - Next state SHR.
- SHR:
  - ALU driven with op=SRL, a=mplier, shamt=1; mplier<=alu_y, cnt<=cnt+1.
  - If cnt==WIDTH-1, next state DONE.
  - Else next state ADD if alu_y[0]=1, otherwise SHL.
- DONE:
  - done=1, busy=1, result<=prod (the registered result is visible in the same cycle via bypass, so result==prod while done=1).
  - ALU driven with AND/0/0/0.
  - Next state IDLE.
- Latency, with start accepted at edge T:
  - Ones = popcount(b_in); N = 2*WIDTH + ones.
  - ALU cycles occupy T+1..T+N; done is high in cycle T+N+1.
  - Range: 65..97 cycles with WIDTH=32.
- start while busy: ignored; no queuing, no effect on operands.
- start in the DONE cycle: ignored; it must be re-presented in IDLE.
- Arithmetic: modulo 2**WIDTH; overflow bits are discarded; no overflow flag.
- alu_b is don't-care in SHL/SHR; drive 0.
- reset mid-operation: abort immediately to reset values; no done pulse; prior result cleared to 0.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN
- Defined: in SHR, if alu_y==0 (remaining multiplier is zero), next state is DONE regardless of cnt.
  - Latency becomes 2*k + ones + 1 cycles to done, where k = index of the highest set bit of b_in, plus 1.
  - b_in==0 goes IDLE->SHL->SHR->DONE, so done comes at T+3.
- Undefined: fixed iteration count of WIDTH, as in Behaviour.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode localparams OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_SRL, shared with the ALU decoder.
  - State encoding for IDLE, ADD, SHL, SHR, DONE.
- No sub-module: the ALU is instantiated by the parent next to this block, not inside it.

Test Plan:
- 3*5, macro off: done at T+67 (64+2+1), result=0x0000000F; busy high T+1..T+67; alu_op trace starts SLL? no — starts ADD, SLL, SRL.
- 0xFFFFFFFF*0xFFFFFFFF -> result=0x00000001, done at T+97; 0x00010000*0x00010000 -> result=0x00000000.
- Early exit on: 3*5 -> result=0xF, done at T+9; 7*0 -> result=0, done at T+3.
- start pulsed with new operands (9,9) at T+10 during busy -> ignored; final result from the original operands; exactly one done pulse.
- reset asserted at T+20 mid-op -> next cycle busy=0, done=0, result=0, alu_op=000; a fresh start 6*7 then yields result=42.
- Back-to-back: start held high continuously -> a new op is accepted in each IDLE cycle after DONE; result holds its value between the done pulse and the next done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes shared between the execute-stage ALU decoder and the
// multiply sequencer, plus the sequencer state encoding.
package alu_pkg;

    localparam int ALU_OP_W    = 3;
    localparam int ALU_SHAMT_W = 5;

    localparam logic [ALU_OP_W-1:0] OP_AND = 3'b000;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b010;
    localparam logic [ALU_OP_W-1:0] OP_SLL = 3'b100;
    localparam logic [ALU_OP_W-1:0] OP_SRL = 3'b101;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b110;
    localparam logic [ALU_OP_W-1:0] OP_SLT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_SHL  = 3'd2,
        ST_SHR  = 3'd3,
        ST_DONE = 3'd4
    } mul_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: 32x32 unsigned multiply (low half of the product) built
// from shift-and-add steps on the shared single-cycle ALU. The ALU itself
// lives in the parent; this block only drives its operands while busy.
//
// Optional build macro: ALU_MUL_EARLY_EXIT_EN -- finish as soon as the
// shifted-down multiplier becomes zero instead of always doing WIDTH rounds.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; ALU parked on AND/0/0/0
// ADD   | prod <= prod + mcand (current multiplier LSB is 1)
// SHL   | mcand <= mcand << 1
// SHR   | mplier <= mplier >> 1, one iteration retired
// DONE  | done pulse, result captured (and bypassed this cycle)
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       a_in,
    input  logic [WIDTH-1:0]       b_in,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic [ALU_OP_W-1:0]    alu_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [ALU_SHAMT_W-1:0] alu_shamt,
    input  logic [WIDTH-1:0]       alu_y
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_t       state;
    mul_state_t       state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

    // the final round is either the WIDTH-th shift or, with early exit,
    // the shift that leaves no set bits in the multiplier
`ifdef ALU_MUL_EARLY_EXIT_EN
    assign last_iter = (cnt == CNT_LAST) || (alu_y == '0);
`else
    assign last_iter = (cnt == CNT_LAST);
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode and ALU operand steering
    always_comb begin
        state_nxt = state;
        alu_op    = OP_AND;
        alu_a     = '0;
        alu_b     = '0;
        alu_shamt = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = b_in[0] ? ST_ADD : ST_SHL;
                end
            end
            ST_ADD: begin
                alu_op    = OP_ADD;
                alu_a     = prod;
                alu_b     = mcand;
                state_nxt = ST_SHL;
            end
            ST_SHL: begin
                alu_op    = OP_SLL;
                alu_a     = mcand;
                alu_shamt = ALU_SHAMT_W'(1);
                state_nxt = ST_SHR;
            end
            ST_SHR: begin
                alu_op    = OP_SRL;
                alu_a     = mplier;
                alu_shamt = ALU_SHAMT_W'(1);
                if (last_iter) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = alu_y[0] ? ST_ADD : ST_SHL;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // operand, accumulator and iteration registers; ALU result written back
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= a_in;
                        mplier <= b_in;
                        prod   <= '0;
                        cnt    <= '0;
                    end
                end
                ST_ADD: begin
                    prod <= alu_y;
                end
                ST_SHL: begin
                    mcand <= alu_y;
                end
                ST_SHR: begin
                    mplier <= alu_y;
                    cnt    <= cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    result_q <= prod;
                end
                default: begin
                end
            endcase
        end
    end

    // status outputs; result bypasses the capture register during DONE
    always_comb begin
        busy   = (state != ST_IDLE);
        done   = (state == ST_DONE);
        result = (state == ST_DONE) ? prod : result_q;
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed and randomized checks of the multiply
// sequencer against a product/latency/op-trace model, with a behavioural
// ALU closing the loop on alu_y.
module tb_alu_mul_sequencer;

    localparam int WIDTH = 32;
    localparam logic [2:0] T_AND = 3'b000;
    localparam logic [2:0] T_OR  = 3'b001;
    localparam logic [2:0] T_ADD = 3'b010;
    localparam logic [2:0] T_SLL = 3'b100;
    localparam logic [2:0] T_SRL = 3'b101;
    localparam logic [2:0] T_SUB = 3'b110;
    localparam logic [2:0] T_SLT = 3'b111;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_y;

    int checks = 0;
    int errors = 0;

    alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_shamt (alu_shamt),
        .alu_y     (alu_y)
    );

    always #5 clk = ~clk;

    // behavioural execute-stage ALU
    always_comb begin
        alu_y = '0;
        case (alu_op)
            T_AND: alu_y = alu_a & alu_b;
            T_OR:  alu_y = alu_a | alu_b;
            T_ADD: alu_y = alu_a + alu_b;
            T_SUB: alu_y = alu_a - alu_b;
            T_SLT: alu_y = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            T_SLL: alu_y = alu_a << alu_shamt;
            T_SRL: alu_y = alu_a >> alu_shamt;
            default: alu_y = '0;
        endcase
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // number of shift-add rounds the multiplier b needs
    function automatic int rounds(input logic [WIDTH-1:0] b);
        int r;
        r = WIDTH;
`ifdef ALU_MUL_EARLY_EXIT_EN
        r = 1;
        for (int i = 0; i < WIDTH; i++) if (b[i]) r = i + 1;
`endif
        return r;
    endfunction

    // cycles from the accepting edge to the done cycle
    function automatic int done_latency(input logic [WIDTH-1:0] b);
        int n;
        n = 0;
        for (int i = 0; i < rounds(b); i++) n += (b[i] ? 3 : 2);
        return n + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full multiply; optionally re-pulses start with other operands at cycle intrude_k
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int intrude_k, input logic [WIDTH-1:0] ia,
                          input logic [WIDTH-1:0] ib, input string tag);
        logic [2:0]       exp_ops[$];
        logic [WIDTH-1:0] exp_res;
        int               n;
        int               done_k;
        bit               trace_ok;
        bit               busy_ok;
        bit               extra_done;
        exp_res = a * b;
        for (int i = 0; i < rounds(b); i++) begin
            if (b[i]) exp_ops.push_back(T_ADD);
            exp_ops.push_back(T_SLL);
            exp_ops.push_back(T_SRL);
        end
        n        = exp_ops.size();
        done_k   = 0;
        trace_ok = 1'b1;
        busy_ok  = 1'b1;
        start    = 1'b1;
        a_in     = a;
        b_in     = b;
        for (int k = 1; k <= n + 12 && done_k == 0; k++) begin
            tick();
            start = 1'b0;
            a_in  = $urandom;
            b_in  = $urandom;
            if (k == intrude_k) begin
                start = 1'b1;
                a_in  = ia;
                b_in  = ib;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                done_k = k;
                check({tag, " result"}, result, exp_res);
            end else if (k <= n && alu_op !== exp_ops[k-1]) begin
                trace_ok = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, " done_cycle"}, done_k, n + 1);
        check({tag, " alu_trace"}, {31'd0, trace_ok}, 32'd1);
        check({tag, " busy_span"}, {31'd0, busy_ok}, 32'd1);
        tick();
        check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, " held_result"}, result, exp_res);
        extra_done = 1'b0;
        repeat (4) begin
            tick();
            if (done !== 1'b0) extra_done = 1'b1;
        end
        check({tag, " single_done"}, {31'd0, extra_done}, 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] r1;
        logic [WIDTH-1:0] a2;
        logic [WIDTH-1:0] b2;
        int               k2;
        bit               held_ok;

        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) tick();
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst alu_op", {29'd0, alu_op}, {29'd0, T_AND});
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("rst alu_shamt", {27'd0, alu_shamt}, 32'd0);
        reset = 1'b0;
        tick();

        run_op(32'd3, 32'd5, 0, '0, '0, "3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0, '0, "ffx ff");
        run_op(32'h0001_0000, 32'h0001_0000, 0, '0, '0, "2^16sq");
        run_op(32'd7, 32'd0, 0, '0, '0, "7x0");
        run_op(32'd12345, 32'h0000_A5A5, 10, 32'd9, 32'd9, "intrude");

        // abort mid-operation
        start = 1'b1;
        a_in  = 32'h1234;
        b_in  = 32'h5678;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort alu_op", {29'd0, alu_op}, {29'd0, T_AND});
        reset = 1'b0;
        tick();
        run_op(32'd6, 32'd7, 0, '0, '0, "6x7");

        // back-to-back with start held high
        start = 1'b1;
        a_in  = 32'hDEAD_BEEF;
        b_in  = 32'h0000_0F31;
        r1    = 32'hDEAD_BEEF * 32'h0000_0F31;
        a2    = $urandom;
        b2    = $urandom;
        k2    = 0;
        for (int k = 1; k <= 120 && k2 == 0; k++) begin
            tick();
            if (done === 1'b1) k2 = k;
        end
        check("b2b first_done", k2, done_latency(32'h0000_0F31));
        check("b2b first_result", result, r1);
        a_in = a2;
        b_in = b2;
        tick();
        check("b2b idle_gap", {31'd0, busy}, 32'd0);
        check("b2b gap_result", result, r1);
        k2      = 0;
        held_ok = 1'b1;
        for (int k = 1; k <= 120 && k2 == 0; k++) begin
            tick();
            if (done === 1'b1) begin
                k2    = k;
                start = 1'b0;
            end else if (result !== r1) begin
                held_ok = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b second_done", k2, done_latency(b2));
        check("b2b second_result", result, a2 * b2);
        check("b2b result_held", {31'd0, held_ok}, 32'd1);
        tick();
        tick();

        // randomized operands
        for (int i = 0; i < 6; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) rb = rb & 32'h0000_0F0F;
            run_op(ra, rb, 0, '0, '0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
